// File: rtl/i2c_eeprom_slave_if.sv
// rtl/i2c_eeprom_slave_if.sv - I2C EEPROM slave control/status bundle (scl in, status out).
// sda stays a plain open-drain inout on the slave so the wired-AND resolves at the pin.
interface i2c_eeprom_slave_if;
  logic       scl;
  logic       busy;
  logic       wr_done;
  logic [8:0] slv_state;

  modport master (output scl, input busy, input wr_done, input slv_state);
  modport slave  (input scl, output busy, output wr_done, output slv_state);
endinterface

// File: rtl/i2c_eeprom_slave.sv
// rtl/i2c_eeprom_slave.sv - I2C EEPROM slave with byte write and random/current read.
// Define EEPROM_AUTOINC_EN to step the address after every written or read byte.
module i2c_eeprom_slave #(
  parameter logic [3:0] DEV_ID = 4'b1010,
  parameter int         ADDR_W = 11
) (
  input  logic               clk,
  input  logic               reset,
  inout  wire                sda,
  i2c_eeprom_slave_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [8:0] {
    IDLE      = 9'b000000001,
    DEV       = 9'b000000010,
    DEV_ACK   = 9'b000000100,
    ADDR      = 9'b000001000,
    ADDR_ACK  = 9'b000010000,
    WDATA     = 9'b000100000,
    WDATA_ACK = 9'b001000000,
    RDATA     = 9'b010000000,
    RDATA_ACK = 9'b100000000
  } state_t;

  state_t              r_state;
  logic [1:0]          r_scl_sync;
  logic [1:0]          r_sda_sync;
  logic                r_scl_prev;
  logic                r_sda_prev;
  logic [3:0]          r_bitcnt;
  logic [7:0]          r_shift;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_rw;
  logic                r_ack_phase;
  logic                r_sda_oe;
  logic                r_busy;
  logic                r_wr_done;
  logic [7:0]          r_mem [DEPTH] = '{default: 8'hFF};

  logic                w_scl;
  logic                w_sda;
  logic                w_scl_rise;
  logic                w_scl_fall;
  logic                w_start;
  logic                w_stop;
  logic [7:0]          w_byte;
  logic                w_mem_we;
  logic [7:0]          w_rdata;
  logic [ADDR_W-1:0]   w_addr_next;

  assign w_scl      = r_scl_sync[1];
  assign w_sda      = r_sda_sync[1];
  assign w_scl_rise = w_scl & ~r_scl_prev;
  assign w_scl_fall = ~w_scl & r_scl_prev;
  // START/STOP need scl high on both samples so our own sda changes at scl low never qualify
  assign w_start    = w_scl & r_scl_prev & r_sda_prev & ~w_sda;
  assign w_stop     = w_scl & r_scl_prev & ~r_sda_prev & w_sda;
  assign w_byte     = {r_shift[6:0], w_sda};
  assign w_mem_we   = (r_state == WDATA) & w_scl_rise & (r_bitcnt == 4'd7);
  assign w_rdata    = r_mem[r_addr];

`ifdef EEPROM_AUTOINC_EN
  assign w_addr_next = r_addr + 1'b1;
`else
  assign w_addr_next = r_addr;
`endif

  assign sda           = r_sda_oe ? 1'b0 : 1'bz;
  assign bus.busy      = r_busy;
  assign bus.wr_done   = r_wr_done;
  assign bus.slv_state = r_state;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_addr] <= w_byte;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_scl_sync  <= 2'b11;
      r_sda_sync  <= 2'b11;
      r_scl_prev  <= 1'b1;
      r_sda_prev  <= 1'b1;
      r_state     <= IDLE;
      r_bitcnt    <= 4'd0;
      r_shift     <= 8'd0;
      r_addr      <= '0;
      r_rw        <= 1'b0;
      r_ack_phase <= 1'b0;
      r_sda_oe    <= 1'b0;
      r_busy      <= 1'b0;
      r_wr_done   <= 1'b0;
    end else begin
      r_scl_sync <= {r_scl_sync[0], bus.scl};
      r_sda_sync <= {r_sda_sync[0], sda};
      r_scl_prev <= w_scl;
      r_sda_prev <= w_sda;
      r_wr_done  <= w_mem_we;

      if (w_start) begin
        r_state     <= DEV;
        r_bitcnt    <= 4'd0;
        r_ack_phase <= 1'b0;
        r_sda_oe    <= 1'b0;
        r_busy      <= 1'b1;
      end else if (w_stop) begin
        r_state     <= IDLE;
        r_bitcnt    <= 4'd0;
        r_ack_phase <= 1'b0;
        r_sda_oe    <= 1'b0;
        r_busy      <= 1'b0;
      end else begin
        case (r_state)
          DEV, ADDR, WDATA: begin
            if (w_scl_rise) begin
              r_shift  <= w_byte;
              r_bitcnt <= r_bitcnt + 4'd1;
              if (r_bitcnt == 4'd7) begin
                r_bitcnt    <= 4'd0;
                r_ack_phase <= 1'b0;
                if (r_state == DEV) begin
                  if (w_byte[7:4] == DEV_ID) begin
                    r_addr[ADDR_W-1:8] <= w_byte[ADDR_W-8:1];
                    r_rw               <= w_byte[0];
                    r_state            <= DEV_ACK;
                  end else begin
                    r_state <= IDLE;
                  end
                end else if (r_state == ADDR) begin
                  r_addr[7:0] <= w_byte;
                  r_state     <= ADDR_ACK;
                end else begin
                  r_addr  <= w_addr_next;
                  r_state <= WDATA_ACK;
                end
              end
            end
          end
          // First scl fall after the 8th bit pulls sda low, the next one releases it
          DEV_ACK, ADDR_ACK, WDATA_ACK: begin
            if (w_scl_fall) begin
              if (!r_ack_phase) begin
                r_sda_oe    <= 1'b1;
                r_ack_phase <= 1'b1;
              end else begin
                r_sda_oe    <= 1'b0;
                r_ack_phase <= 1'b0;
                r_bitcnt    <= 4'd0;
                if (r_state == DEV_ACK && r_rw) begin
                  r_shift  <= w_rdata;
                  r_sda_oe <= ~w_rdata[7];
                  r_state  <= RDATA;
                end else if (r_state == DEV_ACK) begin
                  r_state <= ADDR;
                end else begin
                  r_state <= WDATA;
                end
              end
            end
          end
          RDATA: begin
            if (w_scl_rise) begin
              r_bitcnt <= r_bitcnt + 4'd1;
            end else if (w_scl_fall) begin
              if (r_bitcnt == 4'd8) begin
                r_sda_oe    <= 1'b0;
                r_bitcnt    <= 4'd0;
                r_ack_phase <= 1'b0;
                r_addr      <= w_addr_next;
                r_state     <= RDATA_ACK;
              end else begin
                r_shift  <= {r_shift[6:0], 1'b0};
                r_sda_oe <= ~r_shift[6];
              end
            end
          end
          RDATA_ACK: begin
            if (w_scl_rise) begin
              if (w_sda) begin
                r_state <= IDLE;
              end else begin
                r_ack_phase <= 1'b1;
              end
            end else if (w_scl_fall && r_ack_phase) begin
              r_ack_phase <= 1'b0;
              r_shift     <= w_rdata;
              r_sda_oe    <= ~w_rdata[7];
              r_bitcnt    <= 4'd0;
              r_state     <= RDATA;
            end
          end
          default: begin
            r_sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
